// File: rtl/bp_me_pkg.sv
// Shared memory-engine definitions used by the IO tile command scheduler.
// Holds the default IO-NoC credit limit and scheduler error codes.
package bp_me_pkg;

    localparam int io_noc_max_credits = 8;

    typedef enum logic [1:0] {
        e_sched_err_none           = 2'd0,
        e_sched_err_resp_underflow = 2'd1
    } bp_io_sched_err_e;

endpackage

// File: rtl/bp_io_cmd_scheduler.sv
// Shares one IO-NoC command/response channel pair between several requesters:
// round-robin command issue with credit limiting, in-order response steering.
module bp_io_cmd_scheduler
    import bp_me_pkg::*;
#(
    parameter int num_req_p = 2,
    parameter int msg_width_p = 128,
    parameter int max_credits_p = io_noc_max_credits,
    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int credit_width_lp = $clog2(max_credits_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             drain_i,
    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_cmd_v_i,
    output logic [num_req_p-1:0]             req_cmd_ready_o,
    output logic [msg_width_p-1:0]           io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_ready_i,
    input  logic [msg_width_p-1:0]           io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_yumi_o,
    output logic [msg_width_p-1:0]           req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_ready_i,
    output logic [credit_width_lp-1:0]       credits_used_o,
    output logic                             idle_o,
    output logic                             error_o
);

    localparam int id_ptr_width_lp = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;
    localparam logic [credit_width_lp-1:0] max_cred_lp = credit_width_lp'(max_credits_p);
    localparam logic [lg_num_req_lp-1:0] last_req_lp = lg_num_req_lp'(num_req_p - 1);
    localparam logic [id_ptr_width_lp-1:0] last_slot_lp = id_ptr_width_lp'(max_credits_p - 1);

    logic [lg_num_req_lp-1:0]   rr_ptr_q, rr_ptr_d;
    logic                       io_cmd_v_q, io_cmd_v_d;
    logic [msg_width_p-1:0]     io_cmd_q, io_cmd_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic [credit_width_lp-1:0] id_count_q, id_count_d;
    logic [id_ptr_width_lp-1:0] id_wptr_q, id_wptr_d;
    logic [id_ptr_width_lp-1:0] id_rptr_q, id_rptr_d;
    logic [lg_num_req_lp-1:0]   id_mem_q [max_credits_p];
    logic                       error_q, error_d;

    logic [2*num_req_p-1:0]   req_dbl;
    logic [num_req_p-1:0]     req_rot;
    logic                     found;
    logic [lg_num_req_lp-1:0] winner;
    logic [msg_width_p-1:0]   winner_cmd;
    logic                     slot_free, grant_en, accept;
    logic                     id_empty, id_full, resp_hit, yumi;
    logic [lg_num_req_lp-1:0] head;

    // Rotate valids so bit 0 is the requester at the RR pointer, then priority-pick.
    assign req_dbl = {req_cmd_v_i, req_cmd_v_i};
    assign req_rot = num_req_p'(req_dbl >> rr_ptr_q);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!found && req_rot[i]) begin
                found  = 1'b1;
                winner = lg_num_req_lp'((int'(rr_ptr_q) + i) % num_req_p);
            end
        end
    end

    always_comb begin
        winner_cmd = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (lg_num_req_lp'(i) == winner) begin
                winner_cmd = req_cmd_i[i*msg_width_p +: msg_width_p];
            end
        end
    end

    // Grants use the registered credit count, so a same-cycle yumi cannot free a slot.
    assign slot_free = ~io_cmd_v_q | io_cmd_ready_i;
    assign id_empty  = (id_count_q == '0);
    assign id_full   = (id_count_q == max_cred_lp);
    assign grant_en  = reset_n_i & slot_free & ~drain_i & (credits_q < max_cred_lp) & ~id_full;
    assign accept    = grant_en & found;

    assign req_cmd_ready_o = accept ? (num_req_p'(1) << winner) : '0;

    assign head     = id_mem_q[id_rptr_q];
    assign resp_hit = io_resp_v_i & ~id_empty;
    assign yumi     = resp_hit & req_resp_ready_i[head];

    assign req_resp_v_o   = resp_hit ? (num_req_p'(1) << head) : '0;
    assign io_resp_yumi_o = yumi;
    assign req_resp_o     = io_resp_i;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        io_cmd_v_d = io_cmd_v_q;
        io_cmd_d   = io_cmd_q;
        credits_d  = credits_q;
        id_count_d = id_count_q;
        id_wptr_d  = id_wptr_q;
        id_rptr_d  = id_rptr_q;
        error_d    = error_q | (io_resp_v_i & id_empty);

        if (accept) begin
            io_cmd_v_d = 1'b1;
            io_cmd_d   = winner_cmd;
            rr_ptr_d   = (winner == last_req_lp) ? '0 : winner + lg_num_req_lp'(1);
            id_wptr_d  = (id_wptr_q == last_slot_lp) ? '0 : id_wptr_q + id_ptr_width_lp'(1);
        end else if (io_cmd_ready_i) begin
            io_cmd_v_d = 1'b0;
        end

        if (yumi) begin
            id_rptr_d = (id_rptr_q == last_slot_lp) ? '0 : id_rptr_q + id_ptr_width_lp'(1);
        end

        if (accept && !yumi) begin
            credits_d  = credits_q + credit_width_lp'(1);
            id_count_d = id_count_q + credit_width_lp'(1);
        end else if (!accept && yumi) begin
            credits_d  = credits_q - credit_width_lp'(1);
            id_count_d = id_count_q - credit_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_q   <= '0;
            io_cmd_v_q <= 1'b0;
            io_cmd_q   <= '0;
            credits_q  <= '0;
            id_count_q <= '0;
            id_wptr_q  <= '0;
            id_rptr_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            io_cmd_v_q <= io_cmd_v_d;
            io_cmd_q   <= io_cmd_d;
            credits_q  <= credits_d;
            id_count_q <= id_count_d;
            id_wptr_q  <= id_wptr_d;
            id_rptr_q  <= id_rptr_d;
            error_q    <= error_d;
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_mem_q[id_wptr_q] <= winner;
        end
    end

    assign io_cmd_o       = io_cmd_q;
    assign io_cmd_v_o     = io_cmd_v_q;
    assign credits_used_o = credits_q;
    assign idle_o         = (credits_q == '0) & ~io_cmd_v_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_bp_io_cmd_scheduler.sv
// Self-checking bench for bp_io_cmd_scheduler: directed scenarios plus random
// traffic, all checked against a queue-based transaction model.
module tb_bp_io_cmd_scheduler;

    localparam int N  = 2;
    localparam int W  = 128;
    localparam int C  = 8;
    localparam int CW = 4;
    localparam int VW = 2 + 1 + W + 2 + 1 + W + CW + 1 + 1;

    logic            clk;
    logic            reset_n;
    logic            drain;
    logic [N*W-1:0]  req_cmd;
    logic [N-1:0]    cmd_v;
    logic [N-1:0]    req_cmd_ready_o;
    logic [W-1:0]    io_cmd_o;
    logic            io_cmd_v_o;
    logic            io_cmd_ready;
    logic [W-1:0]    io_resp;
    logic            resp_v;
    logic            io_resp_yumi_o;
    logic [W-1:0]    req_resp_o;
    logic [N-1:0]    req_resp_v_o;
    logic [N-1:0]    resp_ready;
    logic [CW-1:0]   credits_used_o;
    logic            idle_o;
    logic            error_o;

    bp_io_cmd_scheduler #(
        .num_req_p     (N),
        .msg_width_p   (W),
        .max_credits_p (C)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .drain_i          (drain),
        .req_cmd_i        (req_cmd),
        .req_cmd_v_i      (cmd_v),
        .req_cmd_ready_o  (req_cmd_ready_o),
        .io_cmd_o         (io_cmd_o),
        .io_cmd_v_o       (io_cmd_v_o),
        .io_cmd_ready_i   (io_cmd_ready),
        .io_resp_i        (io_resp),
        .io_resp_v_i      (resp_v),
        .io_resp_yumi_o   (io_resp_yumi_o),
        .req_resp_o       (req_resp_o),
        .req_resp_v_o     (req_resp_v_o),
        .req_resp_ready_i (resp_ready),
        .credits_used_o   (credits_used_o),
        .idle_o           (idle_o),
        .error_o          (error_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction model: owners of outstanding commands in issue order.
    int           m_own[$];
    int           m_ptr;
    bit           m_slot_v;
    logic [W-1:0] m_slot;
    bit           m_err;

    logic [N-1:0] e_ready;
    logic [N-1:0] e_resp_v;
    bit           e_yumi;
    bit           e_empty;
    int           e_win;

    logic [VW-1:0] obs_w;
    assign obs_w = {req_cmd_ready_o, io_cmd_v_o, io_cmd_o, req_resp_v_o, io_resp_yumi_o,
                    req_resp_o, credits_used_o, idle_o, error_o};

    task automatic model_reset();
        m_own.delete();
        m_ptr    = 0;
        m_slot_v = 1'b0;
        m_slot   = '0;
        m_err    = 1'b0;
    endtask

    task automatic model_eval();
        int cred;
        bit gen;
        bit found;
        cred    = m_own.size();
        gen     = reset_n && (!m_slot_v || io_cmd_ready) && !drain && (cred < C);
        e_ready = '0;
        found   = 1'b0;
        e_win   = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!found && cmd_v[idx]) begin
                found = 1'b1;
                e_win = idx;
            end
        end
        if (gen && found) e_ready = N'(1 << e_win);
        e_empty  = (cred == 0);
        e_resp_v = '0;
        e_yumi   = 1'b0;
        if (resp_v && !e_empty) begin
            e_resp_v = N'(1 << m_own[0]);
            e_yumi   = resp_ready[m_own[0]];
        end
    endtask

    function automatic logic [VW-1:0] model_vector();
        logic idle;
        idle = (m_own.size() == 0) && !m_slot_v;
        return {e_ready, m_slot_v, m_slot, e_resp_v, e_yumi, io_resp,
                CW'(m_own.size()), idle, m_err};
    endfunction

    // Advance the model by one accepted edge, then move to the next falling edge.
    task automatic tick();
        if (resp_v && e_empty) m_err = 1'b1;
        if (e_yumi) void'(m_own.pop_front());
        if (e_ready != '0) begin
            m_own.push_back(e_win);
            m_slot   = req_cmd[e_win*W +: W];
            m_slot_v = 1'b1;
            m_ptr    = (e_win + 1) % N;
        end else if (io_cmd_ready) begin
            m_slot_v = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_data();
        req_cmd = {8{$urandom}};
        io_resp = {4{$urandom}};
    endtask

    task automatic flush(input string name);
        for (int c = 0; c < 24; c++) begin
            if (m_own.size() == 0 && !m_slot_v) break;
            rand_data();
            cmd_v = '0; io_cmd_ready = 1'b1; resp_v = 1'b1; resp_ready = '1;
            #1; model_eval();
            checks++;
            if (obs_w !== model_vector()) begin
                errors++;
                $display("FAIL %s_flush cyc=%0d got=%h exp=%h", name, c, obs_w, model_vector());
            end
            tick();
        end
        resp_v = 1'b0;
        #1;
        checks++;
        if (idle_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle got=%b exp=1", name, idle_o);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] cmd0;
        reset_n = 1'b0; drain = 1'b0; cmd_v = '1; io_cmd_ready = 1'b1;
        resp_v = 1'b0; resp_ready = '1; rand_data();
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({req_cmd_ready_o, io_cmd_v_o, credits_used_o, error_o, idle_o, req_resp_v_o} !==
            {2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b v=%b cr=%0d err=%b idle=%b rv=%b exp 00/0/0/0/1/00",
                     req_cmd_ready_o, io_cmd_v_o, credits_used_o, error_o, idle_o, req_resp_v_o);
        end
        reset_n = 1'b1;
        model_reset();
        #1; model_eval();
        cmd0 = req_cmd[W-1:0];
        checks++;
        if (req_cmd_ready_o !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant got=%b exp=01", req_cmd_ready_o);
        end
        tick();
        #1;
        checks++;
        if (io_cmd_v_o !== 1'b1 || io_cmd_o !== cmd0) begin
            errors++;
            $display("FAIL reset_first_cmd got v=%b d=%h exp v=1 d=%h", io_cmd_v_o, io_cmd_o, cmd0);
        end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 6; k++) begin
            rand_data();
            cmd_v = '1; io_cmd_ready = 1'b1; resp_v = 1'b0;
            #1; model_eval();
            checks++;
            if (req_cmd_ready_o !== ((k % 2 == 0) ? 2'b10 : 2'b01) || obs_w !== model_vector()) begin
                errors++;
                $display("FAIL alt_grant k=%0d got=%h exp=%h", k, obs_w, model_vector());
            end
            tick();
        end
        for (int k = 0; k < 7; k++) begin
            rand_data();
            cmd_v = '0; resp_v = 1'b1; resp_ready = '1;
            #1; model_eval();
            checks++;
            if (req_resp_v_o !== ((k % 2 == 0) ? 2'b01 : 2'b10) || obs_w !== model_vector()) begin
                errors++;
                $display("FAIL alt_resp k=%0d got=%h exp=%h", k, obs_w, model_vector());
            end
            tick();
        end
        flush("alt");
    endtask

    task automatic test_credit_saturation();
        int acc = 0;
        for (int k = 0; k < 12; k++) begin
            rand_data();
            cmd_v = '1; io_cmd_ready = 1'b1; resp_v = 1'b0;
            #1; model_eval();
            if (e_ready != '0) acc++;
            checks++;
            if (obs_w !== model_vector()) begin
                errors++;
                $display("FAIL sat_fill k=%0d got=%h exp=%h", k, obs_w, model_vector());
            end
            tick();
        end
        #1;
        checks++;
        if (acc != C || credits_used_o !== 4'd8) begin
            errors++;
            $display("FAIL sat_count got acc=%0d cr=%0d exp 8/8", acc, credits_used_o);
        end
        resp_v = 1'b1; resp_ready = '1;
        #1; model_eval();
        checks++;
        if (req_cmd_ready_o !== 2'b00 || io_resp_yumi_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_yumi_cycle got rdy=%b yumi=%b exp 00/1", req_cmd_ready_o, io_resp_yumi_o);
        end
        tick();
        resp_v = 1'b0;
        #1; model_eval();
        checks++;
        if (req_cmd_ready_o === 2'b00 || obs_w !== model_vector()) begin
            errors++;
            $display("FAIL sat_regrant got=%h exp=%h", obs_w, model_vector());
        end
        tick();
        flush("sat");
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [W-1:0] held;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            cmd_v = '1; io_cmd_ready = 1'b0; resp_v = 1'b0;
            #1; model_eval();
            if (e_ready != '0) acc++;
            checks++;
            if (obs_w !== model_vector() || (k > 0 && io_cmd_o !== held)) begin
                errors++;
                $display("FAIL bp_hold k=%0d got=%h exp=%h", k, obs_w, model_vector());
            end
            tick();
            held = m_slot;
        end
        #1;
        checks++;
        if (acc != 1 || credits_used_o !== 4'd1) begin
            errors++;
            $display("FAIL bp_count got acc=%0d cr=%0d exp 1/1", acc, credits_used_o);
        end
        flush("bp");
    endtask

    task automatic test_resp_stall();
        rand_data();
        cmd_v = 2'b10; io_cmd_ready = 1'b1; resp_v = 1'b0;
        #1; model_eval(); tick();
        cmd_v = '0;
        for (int k = 0; k < 4; k++) begin
            io_resp = {4{$urandom}};
            resp_v = 1'b1; resp_ready = (k < 3) ? 2'b01 : 2'b11;
            #1; model_eval();
            checks++;
            if (req_resp_v_o !== 2'b10 || io_resp_yumi_o !== (k == 3) || obs_w !== model_vector()) begin
                errors++;
                $display("FAIL stall k=%0d got=%h exp=%h", k, obs_w, model_vector());
            end
            tick();
        end
        flush("stall");
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            rand_data();
            cmd_v        = N'($urandom_range(0, 3));
            drain        = ($urandom_range(0, 3) == 0);
            io_cmd_ready = ($urandom_range(0, 3) != 0);
            resp_v       = (m_own.size() > 0) && ($urandom_range(0, 1) == 1);
            resp_ready   = N'($urandom_range(0, 3));
            #1; model_eval();
            checks++;
            if (obs_w !== model_vector()) begin
                errors++;
                $display("FAIL random k=%0d got=%h exp=%h", k, obs_w, model_vector());
            end
            tick();
        end
        drain = 1'b0;
        flush("rand");
    endtask

    task automatic test_drain();
        rand_data();
        cmd_v = 2'b01; io_cmd_ready = 1'b0; resp_v = 1'b0;
        #1; model_eval(); tick();
        drain = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            cmd_v = '1; io_cmd_ready = 1'b1;
            #1; model_eval();
            checks++;
            if (req_cmd_ready_o !== 2'b00 || obs_w !== model_vector()) begin
                errors++;
                $display("FAIL drain k=%0d got=%h exp=%h", k, obs_w, model_vector());
            end
            tick();
        end
        flush("drain");
        drain = 1'b0;
    endtask

    task automatic test_error();
        cmd_v = '0; resp_v = 1'b1; resp_ready = '1; io_resp = {4{$urandom}};
        #1; model_eval();
        checks++;
        if (io_resp_yumi_o !== 1'b0 || req_resp_v_o !== 2'b00) begin
            errors++;
            $display("FAIL err_spurious got yumi=%b rv=%b exp 0/00", io_resp_yumi_o, req_resp_v_o);
        end
        tick();
        resp_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1; model_eval();
            checks++;
            if (error_o !== 1'b1 || obs_w !== model_vector()) begin
                errors++;
                $display("FAIL err_sticky k=%0d got=%h exp=%h", k, obs_w, model_vector());
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 4; k++) begin
            rand_data();
            cmd_v = '1; io_cmd_ready = (k != 2); resp_v = 1'b0;
            #1; model_eval(); tick();
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({req_cmd_ready_o, io_cmd_v_o, credits_used_o, error_o, idle_o, req_resp_v_o} !==
            {2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL midreset got rdy=%b v=%b cr=%0d err=%b idle=%b rv=%b exp 00/0/0/0/1/00",
                     req_cmd_ready_o, io_cmd_v_o, credits_used_o, error_o, idle_o, req_resp_v_o);
        end
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        cmd_v = 2'b10;
        #1; model_eval();
        checks++;
        if (obs_w !== model_vector()) begin
            errors++;
            $display("FAIL post_reset got=%h exp=%h", obs_w, model_vector());
        end
        tick();
        flush("post");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alternate();
        test_credit_saturation();
        test_backpressure();
        test_resp_stall();
        test_random();
        test_drain();
        test_error();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
